// File: rtl/tbird_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbird_pkg: shared state encoding and thermometer decode for the    |
// | tail-lamp sequencer family.                                        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package tbird_pkg;

  localparam int c_MAX_LAMPS = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } state_t;

  // k lowest bits set, never beyond the lamp count of the caller.
  function automatic logic [c_MAX_LAMPS-1:0] therm(input logic [4:0] k, input int lamps);
    logic [c_MAX_LAMPS-1:0] v;
    v = '0;
    for (int i = 0; i < c_MAX_LAMPS; i++) begin
      if ((i < lamps) && (i < int'(k))) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tbird_lamp_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbird_lamp_sequencer_if: driver requests in, lamp drives out.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface tbird_lamp_sequencer_if #(
  parameter int LAMPS = 3
) ();

  logic             left;
  logic             right;
  logic             hazard;
  logic             brake;
  logic [LAMPS-1:0] l_lamps;
  logic [LAMPS-1:0] r_lamps;
  logic             tick;

  modport master (
    output left, right, hazard, brake,
    input  l_lamps, r_lamps, tick
  );

  modport slave (
    input  left, right, hazard, brake,
    output l_lamps, r_lamps, tick
  );

endinterface
`default_nettype wire

// File: rtl/tbird_tick_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbird_tick_prescaler: step enable once every TICK_DIV clocks.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tbird_tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick_en
);

  localparam int c_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [c_CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (tick_en) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_CW'(1);
    end
  end

  // With TICK_DIV=1 the counter is pinned at zero and this is always high.
  assign tick_en = (r_count == c_CW'(TICK_DIV - 1));

endmodule
`default_nettype wire

// File: rtl/tbird_lamp_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tbird_lamp_sequencer: sweep-outward turn, hazard and brake lamps.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tbird_lamp_sequencer
  import tbird_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  tbird_lamp_sequencer_if.slave bus
);

  localparam int               c_SW   = $clog2(LAMPS + 1);
  localparam logic [LAMPS-1:0] c_ONES = {LAMPS{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_SW-1:0]  r_step;
  logic [c_SW-1:0]  w_step_nxt;
  logic             r_lreq;
  logic             r_rreq;
  logic             w_clr_req;
  logic             w_eff_l;
  logic             w_eff_r;
  logic             w_tick_en;
  logic [LAMPS-1:0] w_l_nxt;
  logic [LAMPS-1:0] w_r_nxt;
  logic [LAMPS-1:0] r_l;
  logic [LAMPS-1:0] r_r;
  logic             r_tick;

  tbird_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .tick_en (w_tick_en)
  );

  assign w_eff_l = bus.left  | r_lreq;
  assign w_eff_r = bus.right | r_rreq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_lreq  <= 1'b0;
      r_rreq  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      // Consuming a request wins over a request seen on the same edge.
      r_lreq  <= w_clr_req ? 1'b0 : (r_lreq | bus.left);
      r_rreq  <= w_clr_req ? 1'b0 : (r_rreq | bus.right);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (w_tick_en) begin
      case (r_state)
        IDLE: begin
          if (bus.hazard || (w_eff_l && w_eff_r)) begin
            w_state_nxt = HAZ_ON;
            w_step_nxt  = '0;
          end else if (w_eff_l) begin
            w_state_nxt = LEFT;
            w_step_nxt  = c_SW'(1);
          end else if (w_eff_r) begin
            w_state_nxt = RIGHT;
            w_step_nxt  = c_SW'(1);
          end
        end
        LEFT, RIGHT: begin
          if (bus.hazard) begin
            w_state_nxt = HAZ_ON;
            w_step_nxt  = '0;
          end else if (r_step < c_SW'(LAMPS)) begin
            w_step_nxt  = r_step + c_SW'(1);
          end else begin
            w_state_nxt = IDLE;
            w_step_nxt  = '0;
          end
        end
        HAZ_ON: begin
          w_state_nxt = HAZ_OFF;
          w_step_nxt  = '0;
        end
        HAZ_OFF: begin
          w_state_nxt = (bus.hazard || (w_eff_l && w_eff_r)) ? HAZ_ON : IDLE;
          w_step_nxt  = '0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_step_nxt  = '0;
        end
      endcase
    end
  end

  assign w_clr_req = w_tick_en &&
                     (((r_state == IDLE)    && (w_state_nxt != IDLE)) ||
                      ((r_state == HAZ_OFF) && (w_state_nxt == HAZ_ON)));

  // Decode from the next state so a sequence change lands on the same edge.
  always_comb begin
    w_l_nxt = '0;
    w_r_nxt = '0;
    case (w_state_nxt)
      IDLE: begin
        if (bus.brake) begin
          w_l_nxt = c_ONES;
          w_r_nxt = c_ONES;
        end
      end
      LEFT: begin
        w_l_nxt = LAMPS'(therm(5'(w_step_nxt), LAMPS));
        if (bus.brake) w_r_nxt = c_ONES;
      end
      RIGHT: begin
        w_r_nxt = LAMPS'(therm(5'(w_step_nxt), LAMPS));
        if (bus.brake) w_l_nxt = c_ONES;
      end
      HAZ_ON: begin
        w_l_nxt = c_ONES;
        w_r_nxt = c_ONES;
      end
      default: begin
        w_l_nxt = '0;
        w_r_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_l    <= '0;
      r_r    <= '0;
      r_tick <= 1'b0;
    end else begin
      r_l    <= w_l_nxt;
      r_r    <= w_r_nxt;
      r_tick <= w_tick_en;
    end
  end

  assign bus.l_lamps = r_l;
  assign bus.r_lamps = r_r;
  assign bus.tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_tbird_lamp_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tbird_lamp_sequencer: directed checks for 3-lamp/div-1 and      |
// | 5-lamp/div-4 sequencer instances.  Revision: 1.0                   |
// +--------------------------------------------------------------------+
module tb_tbird_lamp_sequencer;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tbird_lamp_sequencer_if #(.LAMPS(3)) ia ();
  tbird_lamp_sequencer_if #(.LAMPS(5)) ib ();

  tbird_lamp_sequencer #(.LAMPS(3), .TICK_DIV(1)) dut_a (
    .clk (clk), .reset (rst_a), .bus (ia.slave)
  );

  tbird_lamp_sequencer #(.LAMPS(5), .TICK_DIV(4)) dut_b (
    .clk (clk), .reset (rst_b), .bus (ib.slave)
  );

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ia.left = 0; ia.right = 0; ia.hazard = 0; ia.brake = 0;
    ib.left = 0; ib.right = 0; ib.hazard = 0; ib.brake = 0;
    rst_a = 1; rst_b = 1;
    edge1();
    edge1();
    n_cmp++;
    if (ia.l_lamps !== 3'b000 || ia.r_lamps !== 3'b000 || ia.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a: l=%b r=%b tick=%b, want 000 000 0", ia.l_lamps, ia.r_lamps, ia.tick);
    end
    rst_a = 0;
  endtask

  task automatic test_left_pulse();
    logic [2:0] el [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000};
    ia.left = 1;
    for (int i = 0; i < 5; i++) begin
      edge1();
      ia.left = 0;
      n_cmp++;
      if (ia.l_lamps !== el[i] || ia.r_lamps !== 3'b000 || ia.tick !== 1'b1) begin
        n_bad++;
        $display("FAIL left_pulse[%0d]: l=%b r=%b tick=%b, want l=%b r=000 tick=1",
                 i, ia.l_lamps, ia.r_lamps, ia.tick, el[i]);
      end
    end
  endtask

  task automatic test_right_held();
    logic [2:0] er [9] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001,
                           3'b011, 3'b111, 3'b000, 3'b000};
    ia.right = 1;
    for (int i = 0; i < 9; i++) begin
      edge1();
      if (i == 4) ia.right = 0;
      n_cmp++;
      if (ia.r_lamps !== er[i] || ia.l_lamps !== 3'b000) begin
        n_bad++;
        $display("FAIL right_held[%0d]: l=%b r=%b, want l=000 r=%b", i, ia.l_lamps, ia.r_lamps, er[i]);
      end
    end
  endtask

  task automatic test_both_and_hazard();
    logic [2:0] eb [6] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000};
    ia.left = 1; ia.right = 1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      if (i == 2) begin ia.left = 0; ia.right = 0; end
      n_cmp++;
      if (ia.l_lamps !== eb[i] || ia.r_lamps !== eb[i]) begin
        n_bad++;
        $display("FAIL both_lr[%0d]: l=%b r=%b, want both %b", i, ia.l_lamps, ia.r_lamps, eb[i]);
      end
    end
    ia.hazard = 1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      if (i == 3) ia.hazard = 0;
      n_cmp++;
      if (ia.l_lamps !== eb[(i < 4) ? (i % 2) : 5] || ia.r_lamps !== eb[(i < 4) ? (i % 2) : 5]) begin
        n_bad++;
        $display("FAIL hazard[%0d]: l=%b r=%b, want both %b", i, ia.l_lamps, ia.r_lamps,
                 eb[(i < 4) ? (i % 2) : 5]);
      end
    end
  endtask

  task automatic test_hazard_preempt();
    logic [2:0] el [6] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000};
    logic [2:0] er [6] = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000};
    ia.left = 1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      ia.left = 0;
      ia.hazard = (i == 1);
      n_cmp++;
      if (ia.l_lamps !== el[i] || ia.r_lamps !== er[i]) begin
        n_bad++;
        $display("FAIL hazard_preempt[%0d]: l=%b r=%b, want l=%b r=%b",
                 i, ia.l_lamps, ia.r_lamps, el[i], er[i]);
      end
    end
  endtask

  task automatic test_brake();
    logic [2:0] el [9] = '{3'b111, 3'b001, 3'b011, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};
    logic [2:0] er [9] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000};
    ia.brake = 1;
    for (int i = 0; i < 9; i++) begin
      edge1();
      ia.left   = (i == 0);
      ia.hazard = (i == 5);
      if (i == 7) ia.brake = 0;
      n_cmp++;
      if (ia.l_lamps !== el[i] || ia.r_lamps !== er[i]) begin
        n_bad++;
        $display("FAIL brake[%0d]: l=%b r=%b, want l=%b r=%b",
                 i, ia.l_lamps, ia.r_lamps, el[i], er[i]);
      end
    end
  endtask

  task automatic test_div4_lamps5();
    logic [4:0] exp_l;
    logic       exp_t;
    int         k;
    edge1();
    rst_b = 0;
    n_cmp++;
    if (ib.l_lamps !== 5'b0 || ib.r_lamps !== 5'b0 || ib.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b: l=%b r=%b tick=%b, want 0 0 0", ib.l_lamps, ib.r_lamps, ib.tick);
    end
    for (int n = 1; n <= 21; n++) begin
      if (n == 2) ib.left = 1;
      edge1();
      ib.left = 0;
      k = (n < 4) ? 0 : ((n / 4 > 5) ? 5 : n / 4);
      exp_l = 5'((1 << k) - 1);
      exp_t = ((n % 4) == 0);
      n_cmp++;
      if (ib.l_lamps !== exp_l || ib.r_lamps !== 5'b0 || ib.tick !== exp_t) begin
        n_bad++;
        $display("FAIL div4_sweep[%0d]: l=%b r=%b tick=%b, want l=%b r=00000 tick=%b",
                 n, ib.l_lamps, ib.r_lamps, ib.tick, exp_l, exp_t);
      end
    end
    rst_b = 1;
    edge1();
    n_cmp++;
    if (ib.l_lamps !== 5'b0 || ib.r_lamps !== 5'b0 || ib.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL div4_reset_mid: l=%b r=%b tick=%b, want 0 0 0", ib.l_lamps, ib.r_lamps, ib.tick);
    end
    rst_b = 0;
    for (int n = 1; n <= 5; n++) begin
      edge1();
      exp_t = (n == 4);
      n_cmp++;
      if (ib.l_lamps !== 5'b0 || ib.tick !== exp_t) begin
        n_bad++;
        $display("FAIL div4_after_reset[%0d]: l=%b tick=%b, want l=00000 tick=%b",
                 n, ib.l_lamps, ib.tick, exp_t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_pulse();
    test_right_held();
    test_both_and_hazard();
    test_hazard_preempt();
    test_brake();
    test_div4_lamps5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tbird_lamp_sequencer.md
Name: tbird_lamp_sequencer

Overview:
Parametrised successor to the three-lamp-per-side Thunderbird tail-light controller. It drives LAMPS lamps per side with the cumulative "sweep outward" turn sequence, and adds hazard flashing, brake overlay and request latching. A programmable tick prescaler sets the sequence step rate. It sits between the driver-input debouncers and the lamp drivers.

Parameters:
LAMPS, 3, lamps per side; legal range 2..16; bit 0 is the innermost lamp (la/ra), bit LAMPS-1 the outermost.
TICK_DIV, 1, clk cycles per sequence step; legal range >=1; 1 gives a step every clock.

Ports:
clk  in  1  single system clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high.
left  in  1  left-turn request (level or pulse).
right  in  1  right-turn request (level or pulse).
hazard  in  1  hazard request (level).
brake  in  1  brake pedal (level).
l_lamps  out  LAMPS  left lamp drives, registered.
r_lamps  out  LAMPS  right lamp drives, registered.
tick  out  1  step strobe, registered; high for one cycle every TICK_DIV cycles.

Behaviour:
- Reset (one clock edge with reset=1): state=IDLE, step=0, prescaler=0, request latches=0, l_lamps=0, r_lamps=0, tick=0. Reset mid-sequence aborts the sequence immediately; the first tick after reset release occurs TICK_DIV cycles later.
- Prescaler: counts 0..TICK_DIV-1 and wraps. Internal tick_en=1 when count==TICK_DIV-1. The tick port is the registered copy of tick_en. With TICK_DIV=1, tick_en is constantly 1.
- Request latches lreq/rreq: set on any edge with left/right high. Effective request eff_l = left|lreq, eff_r = right|rreq. Both latches clear on the edge where the FSM leaves IDLE or HAZ_OFF into any sequence. A pulse shorter than a tick period is therefore never lost.
- FSM advances only on edges with tick_en=1. States: IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF.
  - IDLE: if hazard or (eff_l & eff_r), go to HAZ_ON. Else if eff_l, go to LEFT with step=1. Else if eff_r, go to RIGHT with step=1. Else stay.
  - LEFT/RIGHT: if hazard, go to HAZ_ON (preempts). Else if step<LAMPS, step++. Else (step==LAMPS), go to IDLE with step=0. IDLE then holds for at least one tick with the signalling side off.
  - HAZ_ON goes to HAZ_OFF unconditionally.
  - HAZ_OFF: if hazard or (eff_l & eff_r), go to HAZ_ON. Else go to IDLE.
  - Requests arriving during LEFT/RIGHT are latched and serviced from IDLE. A held level therefore repeats the sweep continuously with a one-tick off gap.
- Lamp decode: thermometer(k) = k lowest bits set.
  - LEFT: l=therm(step), r=0.
  - RIGHT: r=therm(step), l=0.
  - HAZ_ON: l=r=all ones.
  - HAZ_OFF: l=r=0.
  - IDLE: l=r=0.
- Brake overlay:
  - IDLE: both sides all ones.
  - LEFT: r=all ones.
  - RIGHT: l=all ones.
  - HAZ_ON/HAZ_OFF: brake is ignored.
- Output timing: l_lamps/r_lamps update on every edge from (next state, next step, current brake). A sequence change appears in the same edge as the state change. A brake change appears on the first edge after brake changes.
- Widths: step is $clog2(LAMPS+1) bits; prescaler is max(1,$clog2(TICK_DIV)) bits. No arithmetic overflow is possible within the legal parameter ranges.

Decomposition:
- Shared package tbird_pkg holds:
  - state enum (IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF), 3-bit encoding;
  - function therm(k, LAMPS), returning LAMPS bits.
- Sub-module tbird_tick_prescaler (param TICK_DIV; ports clk, reset, tick_en). It is reused by other lamp blocks.

Test Plan:
All scenarios use LAMPS=3, TICK_DIV=1, reset for 1 cycle.
1. left=1 for a single cycle at edge N -> l_lamps = 001, 011, 111, 000 after edges N..N+3; r_lamps=0 throughout.
2. right held high -> r_lamps 001,011,111,000 repeating with period 4; l_lamps=0.
3. left and right both high on the same edge (or hazard=1) -> both sides alternate 111/000 every edge while held; release -> IDLE, outputs 000.
4. Hazard asserted while l_lamps=011 -> next edge both sides 111; the sweep is abandoned.
5. brake=1 in IDLE -> both sides 111 one edge later. brake=1 plus left pulse -> r_lamps=111 steady while l_lamps sweeps 001/011/111, then both 111 in IDLE.
6. LAMPS=5, TICK_DIV=4:
   - left pulse of 1 cycle mid-period is latched;
   - l_lamps steps 00001..11111, each held 4 cycles; tick port pulses every 4 cycles;
   - reset asserted mid-sweep -> all outputs 0 on the next edge.
